// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// FSM encoding, baud codes, parameter defaults and an index-wrap helper.
package uart_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int TIMEOUT_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } arb_state_t;

    localparam logic [2:0] BAUD_9600   = 3'b000;
    localparam logic [2:0] BAUD_19200  = 3'b001;
    localparam logic [2:0] BAUD_38400  = 3'b010;
    localparam logic [2:0] BAUD_57600  = 3'b011;
    localparam logic [2:0] BAUD_115200 = 3'b100;
    localparam logic [2:0] BAUD_230400 = 3'b101;
    localparam logic [2:0] BAUD_460800 = 3'b110;
    localparam logic [2:0] BAUD_921600 = 3'b111;

    // Wraps v into 0..n-1, assuming v < 2*n.
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client-request and transmitter-side signals of the arbiter.
// slave = arbiter side, master = clients plus transmitter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_en;
    logic              tx_busy;
    logic [2:0]        baud_select;

    modport slave (
        input  req,
        input  req_data,
        input  tx_busy,
        output gnt,
        output tx_data,
        output tx_wr,
        output tx_en,
        output baud_select
    );

    modport master (
        output req,
        output req_data,
        output tx_busy,
        input  gnt,
        input  tx_data,
        input  tx_wr,
        input  tx_en,
        input  baud_select
    );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin search: first set req bit at or above ptr,
// wrapping from NREQ-1 back to 0.
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'(wrap_idx(int'(ptr) + i, NREQ));
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ clients,
// with a timeout on the transmitter acknowledging a write.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arb_en,
    input  logic [2:0]        cfg_baud,
    output logic              err_timeout,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr_nxt;
    logic [NREQ-1:0] win_oh;
    logic [7:0]      win_data;
    logic [7:0]      data_arr [NREQ];

    uart_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    for (genvar g = 0; g < NREQ; g++) begin : g_client
        assign data_arr[g] = bus.req_data[g*8 +: 8];
        assign win_oh[g]   = (pick_idx == IW'(g));
    end

    assign win_data = data_arr[pick_idx];
    assign ptr_nxt  = IW'(wrap_idx(int'(pick_idx) + 1, NREQ));

    // arb_en only gates leaving IDLE; a frame in flight always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            cnt             <= '0;
            bus.gnt         <= '0;
            bus.tx_wr       <= 1'b0;
            bus.tx_en       <= 1'b0;
            bus.tx_data     <= 8'h00;
            bus.baud_select <= BAUD_9600;
            err_timeout     <= 1'b0;
        end else begin
            bus.tx_en   <= arb_en;
            bus.gnt     <= '0;
            bus.tx_wr   <= 1'b0;
            err_timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    bus.baud_select <= cfg_baud;
                    if (arb_en && !bus.tx_busy && pick_vld) begin
                        state       <= ST_SEND;
                        bus.gnt     <= win_oh;
                        bus.tx_wr   <= 1'b1;
                        bus.tx_data <= win_data;
                        ptr         <= ptr_nxt;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT_BUSY;
                    cnt   <= '0;
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= ST_WAIT_DONE;
                        cnt   <= '0;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state           <= ST_IDLE;
                        cnt             <= '0;
                        err_timeout     <= 1'b1;
                        bus.baud_select <= cfg_baud;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    // Load baud on the way out so it is valid in the first IDLE cycle.
                    if (!bus.tx_busy) begin
                        state           <= ST_IDLE;
                        bus.baud_select <= cfg_baud;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, TIMEOUT=32).
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    logic       clk;
    logic       reset;
    logic       arb_en;
    logic [2:0] cfg_baud;
    logic       err_timeout;
    int         checks;
    int         errors;

    uart_tx_arbiter_if #(.NREQ(4)) bus ();

    uart_tx_arbiter #(
        .NREQ    (4),
        .TIMEOUT (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arb_en      (arb_en),
        .cfg_baud    (cfg_baud),
        .err_timeout (err_timeout),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for a write, checks it, then runs a normal busy handshake.
    task automatic grant(input string tag, input logic [3:0] eg,
                         input logic [7:0] ed, input bit drop);
        int n;
        n = 0;
        while (!bus.tx_wr && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_wr"}, 32'(bus.tx_wr), 32'(1));
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
        chk({tag, "_data"}, 32'(bus.tx_data), 32'(ed));
        if (drop) bus.req = bus.req & ~bus.gnt;
        tick();
        chk({tag, "_one"}, 32'({bus.tx_wr, bus.gnt}), 32'(0));
        bus.tx_busy = 1'b1;
        tick();
        tick();
        bus.tx_busy = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int wr_cnt;
        int gnt_cnt;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        arb_en       = 1'b0;
        cfg_baud     = 3'b000;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_busy  = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 32'(bus.gnt), 32'(0));
        chk("rst_wr", 32'(bus.tx_wr), 32'(0));
        chk("rst_en", 32'(bus.tx_en), 32'(0));
        chk("rst_data", 32'(bus.tx_data), 32'(0));
        chk("rst_baud", 32'(bus.baud_select), 32'(0));
        chk("rst_err", 32'(err_timeout), 32'(0));
        reset = 1'b0;

        // Two sparse requests, then a probe that ptr landed on 3.
        arb_en       = 1'b1;
        cfg_baud     = 3'b010;
        bus.req_data = {8'h00, 8'h3C, 8'h00, 8'hA5};
        bus.req      = 4'b0101;
        grant("sp0", 4'b0001, 8'hA5, 1'b1);
        chk("en_on", 32'(bus.tx_en), 32'(1));
        chk("baud_idle", 32'(bus.baud_select), 32'(3'b010));
        grant("sp1", 4'b0100, 8'h3C, 1'b1);
        bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req      = 4'b1011;
        grant("ptr3", 4'b1000, 8'h44, 1'b0);

        // All clients requesting: strict rotation.
        bus.req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            logic [3:0] oh;
            logic [7:0] d;
            oh = 4'b0001 << (f % 4);
            d  = 8'h11 * 8'((f % 4) + 1);
            grant($sformatf("rr%0d", f), oh, d, 1'b0);
        end

        // Transmitter never goes busy: timeout path (ptr is 0 here).
        bus.req = 4'b0010;
        tick();
        chk("to_wr", 32'(bus.tx_wr), 32'(1));
        chk("to_gnt", 32'(bus.gnt), 32'(4'b0010));
        bus.req = 4'b0000;
        n = 0;
        while (!err_timeout && n < 40) begin
            tick();
            n++;
        end
        chk("to_lat", 32'(n), 32'(33));
        bus.req = 4'b0100;
        tick();
        chk("to_pulse", 32'(err_timeout), 32'(0));
        chk("to_next_wr", 32'(bus.tx_wr), 32'(1));
        chk("to_next_gnt", 32'(bus.gnt), 32'(4'b0100));
        chk("to_next_data", 32'(bus.tx_data), 32'(8'h33));
        grant("to_fin", 4'b0100, 8'h33, 1'b1);

        // Baud change during WAIT_DONE is deferred to IDLE.
        bus.req = 4'b0001;
        tick();
        chk("bd_gnt", 32'(bus.gnt), 32'(4'b0001));
        bus.req = 4'b0000;
        tick();
        bus.tx_busy = 1'b1;
        tick();
        cfg_baud = 3'b111;
        tick();
        chk("bd_hold0", 32'(bus.baud_select), 32'(3'b010));
        tick();
        chk("bd_hold1", 32'(bus.baud_select), 32'(3'b010));
        bus.tx_busy = 1'b0;
        tick();
        chk("bd_load", 32'(bus.baud_select), 32'(3'b111));

        // Asynchronous reset in WAIT_DONE.
        bus.req = 4'b0001;
        tick();
        chk("ar_gnt", 32'(bus.gnt), 32'(4'b0001));
        bus.req = 4'b0000;
        tick();
        bus.tx_busy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("ar_data", 32'(bus.tx_data), 32'(0));
        chk("ar_baud", 32'(bus.baud_select), 32'(0));
        chk("ar_en", 32'({bus.tx_en, bus.tx_wr, bus.gnt, err_timeout}), 32'(0));
        bus.tx_busy = 1'b0;
        tick();
        reset   = 1'b0;
        bus.req = 4'b0010;
        grant("ar_rel", 4'b0010, 8'h22, 1'b1);

        // Disabled arbiter ignores requests.
        arb_en  = 1'b0;
        bus.req = 4'b1111;
        wr_cnt  = 0;
        gnt_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (bus.tx_wr) wr_cnt++;
            if (bus.gnt != 4'b0000) gnt_cnt++;
        end
        chk("dis_wr", 32'(wr_cnt), 32'(0));
        chk("dis_gnt", 32'(gnt_cnt), 32'(0));
        chk("dis_en", 32'(bus.tx_en), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
